rv32i_writeback_ctrl: RTL

- Parametrised next-generation writeback stage: selects the rd value, computes and registers the next PC, and handles traps and mret.
- Adds three capabilities:
  - A valid/ready handshake with a wait state for variable-latency load data.
  - Misaligned-target detection.
  - A retired-instruction counter.
- Sits between the memory-access stage and the register file / fetch PC mux.

---
 rtl/rv32i_writeback_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/rv32i_writeback_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_writeback_ctrl
// Purpose  : RV32I writeback stage - rd select, next-PC, traps/mret, load wait,
//            misaligned-target detection and retired-instruction counting.
// Revision : 1.0
// ============================================================================
module rv32i_writeback_ctrl #(
    parameter int          XLEN     = 32,
    parameter logic [31:0] PC_RESET = 32'h0,
    parameter int          IALIGN   = 32,
    parameter int          RET_W    = 64
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [10:0]      i_opcode,
    input  logic [2:0]       i_funct3,
    input  logic [XLEN-1:0]  i_alu_out,
    input  logic [XLEN-1:0]  i_imm,
    input  logic [XLEN-1:0]  i_rs1,
    input  logic [XLEN-1:0]  i_data_load,
    input  logic             i_load_valid,
    input  logic [XLEN-1:0]  i_csr_out,
    input  logic             i_go_to_trap,
    input  logic             i_return_from_trap,
    input  logic [XLEN-1:0]  i_trap_address,
    input  logic [XLEN-1:0]  i_return_address,
    output logic [XLEN-1:0]  o_rd,
    output logic             o_wr_rd,
    output logic [XLEN-1:0]  o_pc,
    output logic             o_valid,
    output logic             o_flush,
    output logic             o_misaligned,
    output logic [XLEN-1:0]  o_bad_addr,
    output logic [RET_W-1:0] o_retired
);

    typedef enum logic [0:0] {
        S_IDLE      = 1'b0,
        S_LOAD_WAIT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   rd_q, rd_d;
    logic [XLEN-1:0]   bad_q, bad_d;
    logic [RET_W-1:0]  ret_q, ret_d;
    logic              wr_q, wr_d;
    logic              valid_q, valid_d;
    logic              flush_q, flush_d;
    logic              mis_q, mis_d;

    logic              is_rtype, is_itype, is_load, is_store, is_branch;
    logic              is_jal, is_jalr, is_lui, is_auipc, is_system, is_fence;
    logic [XLEN-1:0]   w_sum, w_seq, w_target, w_rd_sel;
    logic              w_redirect, w_misaligned, w_wr_en, w_retire;

    assign is_rtype  = i_opcode[0];
    assign is_itype  = i_opcode[1];
    assign is_load   = i_opcode[2];
    assign is_store  = i_opcode[3];
    assign is_branch = i_opcode[4];
    assign is_jal    = i_opcode[5];
    assign is_jalr   = i_opcode[6];
    assign is_lui    = i_opcode[7];
    assign is_auipc  = i_opcode[8];
    assign is_system = i_opcode[9];
    assign is_fence  = i_opcode[10];

    // One adder serves auipc, branch, jal and jalr targets.
    assign w_sum    = (is_jalr ? i_rs1 : pc_q) + i_imm;
    assign w_seq    = pc_q + XLEN'(4);
    assign w_target = is_jalr ? {w_sum[XLEN-1:1], 1'b0} : w_sum;

    assign w_redirect   = is_jal | is_jalr | (is_branch & i_alu_out[0]);
    assign w_misaligned = (IALIGN == 16) ? w_target[0] : (w_target[1:0] != 2'b00);

    assign w_wr_en = (|i_opcode) &
                     ~(is_store | is_branch | is_fence | (is_system & (i_funct3 == 3'b000)));

    always_comb begin
        w_rd_sel = '0;
        if (is_rtype | is_itype)      w_rd_sel = i_alu_out;
        else if (is_load)             w_rd_sel = i_data_load;
        else if (is_jal | is_jalr)    w_rd_sel = w_seq;
        else if (is_lui)              w_rd_sel = i_imm;
        else if (is_auipc)            w_rd_sel = w_sum;
        else if (is_system)           w_rd_sel = i_csr_out;
    end

    assign o_ready = (state_q == S_IDLE);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        rd_d     = rd_q;
        bad_d    = bad_q;
        ret_d    = ret_q;
        wr_d     = 1'b0;
        valid_d  = 1'b0;
        flush_d  = 1'b0;
        mis_d    = 1'b0;
        w_retire = 1'b0;
        if (state_q == S_IDLE) begin
            if (i_go_to_trap) begin
                pc_d    = i_trap_address;
                flush_d = 1'b1;
            end else if (i_return_from_trap) begin
                pc_d    = i_return_address;
                flush_d = 1'b1;
            end else if (i_valid) begin
                if (is_load && !i_load_valid) begin
                    state_d = S_LOAD_WAIT;
                end else if (w_redirect && w_misaligned) begin
                    mis_d = 1'b1;
                    bad_d = w_target;
                end else begin
                    pc_d     = w_redirect ? w_target : w_seq;
                    flush_d  = w_redirect;
                    wr_d     = w_wr_en;
                    w_retire = 1'b1;
                    if (w_wr_en) rd_d = w_rd_sel;
                end
            end
        end else begin
            // mret is deliberately ignored while a load is outstanding.
            if (i_go_to_trap) begin
                pc_d    = i_trap_address;
                flush_d = 1'b1;
                state_d = S_IDLE;
            end else if (i_load_valid) begin
                rd_d     = i_data_load;
                wr_d     = 1'b1;
                pc_d     = w_seq;
                w_retire = 1'b1;
                state_d  = S_IDLE;
            end
        end
        if (w_retire) begin
            valid_d = 1'b1;
            ret_d   = ret_q + RET_W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            pc_q    <= XLEN'(PC_RESET);
            rd_q    <= '0;
            bad_q   <= '0;
            ret_q   <= '0;
            wr_q    <= 1'b0;
            valid_q <= 1'b0;
            flush_q <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            rd_q    <= rd_d;
            bad_q   <= bad_d;
            ret_q   <= ret_d;
            wr_q    <= wr_d;
            valid_q <= valid_d;
            flush_q <= flush_d;
            mis_q   <= mis_d;
        end
    end

    assign o_pc         = pc_q;
    assign o_rd         = rd_q;
    assign o_bad_addr   = bad_q;
    assign o_retired    = ret_q;
    assign o_wr_rd      = wr_q;
    assign o_valid      = valid_q;
    assign o_flush      = flush_q;
    assign o_misaligned = mis_q;

endmodule
`default_nettype wire
